// File: rtl/serial_tx.sv
// serial_tx: UART transmit serializer, 8N1, LSB first, idle-high line.
// Bit timing is derived from a clock-cycle counter (CLK_PER_BIT cycles/bit).
// Optional build macro SERIAL_TX_PARITY_EN inserts an even-parity bit (8E1).
module serial_tx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data
);

  localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP_BIT
  } state_t;

  state_t              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          data_q, data_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic                ctr_last;
  logic [2:0]          bit_nxt;

  assign ctr_last = (ctr_q == CTR_LAST);
  assign bit_nxt  = bit_q + 3'd1;

  assign tx   = tx_q;
  assign busy = busy_q;

  // State and output registers; reset truncates any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs change only through registers.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = block;
        ctr_d  = '0;
        bit_d  = '0;
        if (new_data && !block) begin
          data_d  = data;
          state_d = START_BIT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START_BIT: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_last) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end

      DATA: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_last) begin
          ctr_d = '0;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP_BIT;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_last) begin
          ctr_d   = '0;
          state_d = STOP_BIT;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP_BIT: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_last) begin
          ctr_d   = '0;
          state_d = IDLE;
          busy_d  = block;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ctr_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx with CLK_PER_BIT=4.
module tb_serial_tx;

  localparam int CPB = 4;
  localparam int PER = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 11 * CPB;
`else
  localparam int FL = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       block;
  logic       busy;
  logic [7:0] data;
  logic       new_data;

  int  errors = 0;
  int  checks = 0;
  time t_acc  = 0;
  time t_prev = 0;
  logic last_par = 1'b0;

  always #(PER/2) clk = ~clk;

  serial_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (tx),
    .block    (block),
    .busy     (busy),
    .data     (data),
    .new_data (new_data)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE with busy low; returns at the negedge of the
  // idle cycle that follows the frame, so a caller may strobe the next byte.
  task automatic send_frame(input logic [7:0] b, input bit inject, input bit blk_mid);
    logic exp_tx;
    int   j;
    data     = b;
    new_data = 1'b1;
    @(posedge clk);
    t_acc = $time;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (k == 0) new_data = 1'b0;
      if (inject && k == 10) begin
        new_data = 1'b1;
        data     = 8'hFF;
      end
      if (inject && k == 11) new_data = 1'b0;
      if (blk_mid && k == 10) block = 1'b1;
      j = k / CPB;
      if (j == 0) exp_tx = 1'b0;
      else if (j <= 8) exp_tx = b[j-1];
`ifdef SERIAL_TX_PARITY_EN
      else if (j == 9) begin
        exp_tx   = ^b;
        last_par = tx;
      end
`endif
      else exp_tx = 1'b1;
      check("frame_tx", tx, exp_tx);
      check("frame_busy", busy, 1'b1);
    end
    @(negedge clk);
    check("end_busy", busy, blk_mid);
    check("end_tx", tx, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    block    = 1'b0;
    new_data = 1'b0;
    data     = 8'h00;

    // Test 1: reset in idle, then reset in the middle of data bit 3.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle_tx", tx, 1'b1);
    check("rst_idle_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    data     = 8'h41;
    new_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    new_data = 1'b0;
    repeat (16) @(negedge clk);
    check("bit3_tx", tx, 1'b0);
    check("bit3_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_abort_tx", tx, 1'b1);
    check("after_abort_busy", busy, 1'b0);

    // Tests 2/3: frame for 0x41 with a 0xFF strobe injected mid-frame.
    send_frame(8'h41, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("no_ff_frame_tx", tx, 1'b1);
    check("no_ff_frame_busy", busy, 1'b0);

    // Test 4: back-to-back handshake, bytes 0x30..0x39, one idle cycle apart.
    for (int i = 0; i < 10; i++) begin
      send_frame(8'(8'h30 + i), 1'b0, 1'b0);
      if (i > 0) check_val("frame_gap", longint'(t_acc - t_prev), longint'((FL + 1) * PER));
      t_prev = t_acc;
    end

    // Test 5: block in idle drops a byte; block during a frame holds busy.
    block = 1'b1;
    @(negedge clk);
    check("blk_busy", busy, 1'b1);
    check("blk_tx", tx, 1'b1);
    data     = 8'h55;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blk_drop_tx", tx, 1'b1);
      check("blk_drop_busy", busy, 1'b1);
    end
    block = 1'b0;
    @(negedge clk);
    check("unblk_busy", busy, 1'b0);
    check("unblk_tx", tx, 1'b1);

    send_frame(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blk_hold_busy", busy, 1'b1);
      check("blk_hold_tx", tx, 1'b1);
    end
    block = 1'b0;
    @(negedge clk);
    check("blk_release_busy", busy, 1'b0);

`ifdef SERIAL_TX_PARITY_EN
    // Test 6: even parity bit values for two hand-computed bytes.
    send_frame(8'h41, 1'b0, 1'b0);
    check("par_41", last_par, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0);
    check("par_07", last_par, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
